// File: rtl/md5_pad_feeder.sv
// md5_pad_feeder: byte-stream front end for an md5sum core.
// Packs bytes little-endian into 32-bit words, appends MD5 padding
// (0x80, zero fill, 64-bit little-endian bit length), feeds 16-word
// blocks over rdy/write_en and waits for done between blocks.
module md5_pad_feeder #(
    parameter int LEN_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        core_rst_n,
    input  logic        core_rdy,
    output logic [31:0] core_msg,
    output logic        core_write_en,
    input  logic        core_done,
    output logic        busy,
    output logic        digest_valid
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_DATA  = 3'd2,
        ST_PADW  = 3'd3,
        ST_FILL  = 3'd4,
        ST_LEN   = 3'd5,
        ST_WAITD = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    state_t             state_r;
    state_t             ret_r;        // state to resume after the block's done
    logic               final_r;      // the block just sent is the last one
    logic [31:0]        ow_r;         // output word register
    logic               ow_v_r;
    logic [1:0]         lane_r;
    logic [3:0]         widx_r;
    logic [LEN_W-1:0]   bcnt_r;
    logic [31:0]        acc_r;        // partially assembled data word
    logic [1:0]         lp_r;         // length phase: 0 low word, 1 high word, 2 sent
    logic               core_rst_n_r;

    logic               xfer_s;
    logic               slot_s;
    logic               blk_end_s;
    logic [3:0]         load_idx_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [63:0]        len_s;
    logic [31:0]        dword_s;
    state_t             work_nxt_s;
    logic               load_s;
    logic [31:0]        load_word_s;

    // A word leaves ow whenever it is valid and the core is ready, except
    // while parked for the core's done (ow may already hold the next block).
    assign xfer_s     = ow_v_r & core_rdy & (state_r != ST_WAITD);
    assign slot_s     = ~ow_v_r | xfer_s;
    assign blk_end_s  = xfer_s & (widx_r == 4'd15);
    // Block index the next loaded word will occupy.
    assign load_idx_s = ow_v_r ? (widx_r + 4'd1) : widx_r;
    assign in_ready_s = (state_r == ST_DATA) & (~ow_v_r | core_rdy);
    assign accept_s   = in_valid & in_ready_s;

    assign in_ready      = in_ready_s;
    assign core_write_en = xfer_s;
    assign core_msg      = ow_r;
    assign core_rst_n    = core_rst_n_r;
    assign busy          = (state_r != ST_IDLE);
    assign digest_valid  = (state_r == ST_DONE);

    // Message bit length, zero-extended to 64 bits.
    always_comb begin
        len_s = 64'h0;
        len_s[LEN_W+2:3] = bcnt_r;
    end

    // Assemble the data word: earlier lanes from acc, the current byte, and
    // on the final byte the 0x80 marker in the next lane with zeros above.
    always_comb begin
        dword_s = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k[1:0] < lane_r) begin
                dword_s[8*k +: 8] = acc_r[8*k +: 8];
            end else if (k[1:0] == lane_r) begin
                dword_s[8*k +: 8] = in_data;
            end else if (in_last && (k[1:0] == (lane_r + 2'd1))) begin
                dword_s[8*k +: 8] = 8'h80;
            end else begin
                dword_s[8*k +: 8] = 8'h00;
            end
        end
    end

    // Next working state and what (if anything) is loaded into ow this cycle.
    always_comb begin
        work_nxt_s  = state_r;
        load_s      = 1'b0;
        load_word_s = 32'h0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    work_nxt_s = ST_INIT;
                end else begin
                    work_nxt_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                work_nxt_s = ST_DATA;
            end
            ST_DATA: begin
                if (accept_s && in_last) begin
                    load_s      = 1'b1;
                    load_word_s = dword_s;
                    work_nxt_s  = (lane_r == 2'd3) ? ST_PADW : ST_FILL;
                end else if (accept_s && (lane_r == 2'd3)) begin
                    load_s      = 1'b1;
                    load_word_s = dword_s;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_PADW: begin
                if (slot_s) begin
                    load_s      = 1'b1;
                    load_word_s = 32'h0000_0080;
                    work_nxt_s  = ST_FILL;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_FILL: begin
                // Word 14 is reserved for the length; anything else is zero fill,
                // including the tail of a block where the marker spilled past 13.
                if (load_idx_s == 4'd14) begin
                    work_nxt_s = ST_LEN;
                end else if (slot_s) begin
                    load_s      = 1'b1;
                    load_word_s = 32'h0;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_LEN: begin
                if (slot_s && (lp_r < 2'd2)) begin
                    load_s      = 1'b1;
                    load_word_s = (lp_r == 2'd0) ? len_s[31:0] : len_s[63:32];
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_WAITD: begin
                if (core_done) begin
                    work_nxt_s = final_r ? ST_DONE : ret_r;
                end else begin
                    work_nxt_s = ST_WAITD;
                end
            end
            ST_DONE: begin
                work_nxt_s = ST_IDLE;
            end
            default: begin
                work_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequential state: FSM, output word register, counters and core reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            ret_r        <= ST_IDLE;
            final_r      <= 1'b0;
            ow_r         <= 32'h0;
            ow_v_r       <= 1'b0;
            lane_r       <= 2'd0;
            widx_r       <= 4'd0;
            bcnt_r       <= '0;
            acc_r        <= 32'h0;
            lp_r         <= 2'd0;
            core_rst_n_r <= 1'b0;
        end else begin
            if (load_s) begin
                ow_r   <= load_word_s;
                ow_v_r <= 1'b1;
            end else if (xfer_s) begin
                ow_v_r <= 1'b0;
            end

            if (xfer_s) begin
                widx_r <= widx_r + 4'd1;
            end

            if (accept_s) begin
                bcnt_r                <= bcnt_r + 1'b1;
                acc_r[8*lane_r +: 8]  <= in_data;
                lane_r                <= in_last ? 2'd0 : (lane_r + 2'd1);
            end

            if ((state_r == ST_LEN) && load_s) begin
                lp_r <= lp_r + 2'd1;
            end

            if (blk_end_s) begin
                state_r <= ST_WAITD;
                ret_r   <= work_nxt_s;
                final_r <= (state_r == ST_LEN);
            end else begin
                state_r <= work_nxt_s;
            end

            // Core reset is low exactly during the INIT cycle.
            core_rst_n_r <= (work_nxt_s != ST_INIT);

            // Fresh message: clear all per-message bookkeeping.
            if (state_r == ST_INIT) begin
                ow_v_r  <= 1'b0;
                lane_r  <= 2'd0;
                widx_r  <= 4'd0;
                bcnt_r  <= '0;
                lp_r    <= 2'd0;
                final_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_md5_pad_feeder.sv
// Testbench for md5_pad_feeder: behavioural md5sum core model plus a
// software MD5 reference computed directly from the message bytes.
module tb_md5_pad_feeder;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        core_rst_n;
    logic        core_rdy;
    logic [31:0] core_msg;
    logic        core_write_en;
    logic        core_done;
    logic        busy;
    logic        digest_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    md5_pad_feeder #(.LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .core_rst_n(core_rst_n),
        .core_rdy(core_rdy), .core_msg(core_msg), .core_write_en(core_write_en),
        .core_done(core_done), .busy(busy), .digest_valid(digest_valid)
    );

    localparam logic [127:0] IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

    logic [31:0] k_tab [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
    int sh_tab [0:15] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        return (x << s) | (x >> (32 - s));
    endfunction

    // One MD5 compression; state packed as {a,b,c,d}.
    function automatic logic [127:0] md5_block(input logic [127:0] st, input logic [31:0] m [16]);
        logic [31:0] a, b, c, d, f, t;
        int g;
        a = st[127:96]; b = st[95:64]; c = st[63:32]; d = st[31:0];
        for (int i = 0; i < 64; i++) begin
            case (i / 16)
                0:       begin f = (b & c) | (~b & d); g = i;                end
                1:       begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
                2:       begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
                default: begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            endcase
            t = a + f + k_tab[i] + m[g];
            a = d; d = c; c = b;
            b = b + rotl(t, sh_tab[(i / 16) * 4 + (i % 4)]);
        end
        return {st[127:96] + a, st[95:64] + b, st[63:32] + c, st[31:0] + d};
    endfunction

    // Standard MD5 padding on the byte level, then little-endian word packing.
    function automatic wq_t pad_words(input bq_t msg);
        bq_t p;
        wq_t w;
        logic [63:0] bits;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int j = 0; j < 8; j++) p.push_back(bits[8*j +: 8]);
        for (int i = 0; i < p.size() / 4; i++)
            w.push_back({p[4*i+3], p[4*i+2], p[4*i+1], p[4*i]});
        return w;
    endfunction

    function automatic logic [127:0] md5_ref(input wq_t w);
        logic [127:0] st;
        logic [31:0]  m [16];
        st = IV;
        for (int bl = 0; bl < w.size() / 16; bl++) begin
            for (int j = 0; j < 16; j++) m[j] = w[16*bl + j];
            st = md5_block(st, m);
        end
        return st;
    endfunction

    // ---------------- core model ----------------
    logic [127:0] m_st = IV;
    logic [31:0]  m_blk [16];
    int           m_wcnt = 0;
    int           m_cd = 0;
    bit           rnd_rdy = 1'b0;
    wq_t          wlog;
    int           dv_cnt = 0;
    int           rst_pulses = 0;
    logic         prev_crst = 1'b1;
    logic [127:0] dig_snap = 128'h0;
    int           first_wait = 0;

    initial begin
        core_rdy  = 1'b0;
        core_done = 1'b0;
    end

    // Drive rdy/done at negedge, sample the transfer just before posedge.
    always begin
        @(negedge clk);
        core_done = (m_cd == 1);
        core_rdy  = (m_cd == 0 && m_wcnt < 16) ? (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b0;
        #4;
        if (digest_valid) begin
            dv_cnt++;
            dig_snap = m_st;
        end
        if (!core_rst_n && prev_crst) rst_pulses++;
        prev_crst = core_rst_n;
        if (!core_rst_n) begin
            m_st = IV; m_wcnt = 0; m_cd = 0;
        end else if (core_write_en) begin
            total++;
            if (!core_rdy || m_wcnt >= 16) begin
                bad++;
                $display("FAIL write_en_without_rdy: write_en=1 rdy=%0b words_in_block=%0d, required rdy=1", core_rdy, m_wcnt);
            end else begin
                m_blk[m_wcnt] = core_msg;
                m_wcnt++;
                wlog.push_back(core_msg);
                if (m_wcnt == 16) begin
                    m_st = md5_block(m_st, m_blk);
                    m_cd = 51;
                end
            end
        end else if (m_cd != 0) begin
            m_cd--;
            if (m_cd == 0) m_wcnt = 0;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_bytes(input bq_t msg, input int gap, input bit with_last);
        int i;
        int cyc;
        i = 0; cyc = 0;
        while (i < msg.size() && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (gap > 0 && $urandom_range(0, 99) < gap) begin
                in_valid = 1'b0; in_last = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = msg[i];
                in_last  = with_last && (i == msg.size() - 1);
            end
            #4;
            if (in_valid && in_ready) begin
                if (i == 0) first_wait = cyc;
                i++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        total++;
        if (i != msg.size()) begin
            bad++;
            $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, msg.size());
        end
    endtask

    task automatic run_msg(input bq_t msg, input int gap, input bit rr, input string name, output wq_t got);
        wq_t exp;
        logic [127:0] ref_d;
        int dv0, rp0, n;
        exp = pad_words(msg);
        ref_d = md5_ref(exp);
        wlog.delete();
        dv0 = dv_cnt; rp0 = rst_pulses; rnd_rdy = rr;
        send_bytes(msg, gap, 1'b1);
        n = 0;
        while (dv_cnt == dv0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        total++;
        if (dv_cnt != dv0 + 1) begin
            bad++; $display("FAIL %s digest_valid_count: got %0d, required 1", name, dv_cnt - dv0);
        end
        total++;
        if (wlog.size() != exp.size()) begin
            bad++; $display("FAIL %s word_count: got %0d, required %0d", name, wlog.size(), exp.size());
        end
        for (int i = 0; i < wlog.size() && i < exp.size(); i++) begin
            total++;
            if (wlog[i] !== exp[i]) begin
                bad++; $display("FAIL %s word[%0d]: got %08h, required %08h", name, i, wlog[i], exp[i]);
            end
        end
        total++;
        if (dig_snap !== ref_d) begin
            bad++; $display("FAIL %s digest: got %032h, required %032h", name, dig_snap, ref_d);
        end
        total++;
        if (rst_pulses != rp0 + 1) begin
            bad++; $display("FAIL %s core_rst_n_pulses: got %0d, required 1", name, rst_pulses - rp0);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s busy_after: got %0b, required 0", name, busy);
        end
        got = wlog;
    endtask

    function automatic bq_t fill_bytes(input int n, input logic [7:0] v);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(v);
        return q;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    function automatic bq_t abc_msg();
        bq_t q;
        q.push_back(8'h61); q.push_back(8'h62); q.push_back(8'h63);
        return q;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        repeat (3) @(negedge clk);
        total++; if (core_rst_n !== 1'b0)     begin bad++; $display("FAIL reset core_rst_n: got %0b, required 0", core_rst_n); end
        total++; if (in_ready !== 1'b0)       begin bad++; $display("FAIL reset in_ready: got %0b, required 0", in_ready); end
        total++; if (core_write_en !== 1'b0)  begin bad++; $display("FAIL reset core_write_en: got %0b, required 0", core_write_en); end
        total++; if (core_msg !== 32'h0)      begin bad++; $display("FAIL reset core_msg: got %08h, required 0", core_msg); end
        total++; if (busy !== 1'b0)           begin bad++; $display("FAIL reset busy: got %0b, required 0", busy); end
        total++; if (digest_valid !== 1'b0)   begin bad++; $display("FAIL reset digest_valid: got %0b, required 0", digest_valid); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_abc(input wq_t got, input string name);
        total++;
        if (dig_snap !== 128'h98500190_b04fd23c_7d3f96d6_727fe128) begin
            bad++; $display("FAIL %s abc_digest: got %032h, required 98500190b04fd23c7d3f96d6727fe128", name, dig_snap);
        end
        if (got.size() >= 16) begin
            total++; if (got[0] !== 32'h80636261)  begin bad++; $display("FAIL %s abc_word0: got %08h, required 80636261", name, got[0]); end
            total++; if (got[14] !== 32'h00000018) begin bad++; $display("FAIL %s abc_word14: got %08h, required 00000018", name, got[14]); end
        end
    endtask

    task automatic test_abc();
        wq_t got;
        run_msg(abc_msg(), 0, 1'b0, "abc", got);
        check_abc(got, "abc");
        total++;
        if (first_wait != 3) begin
            bad++; $display("FAIL abc first_accept_cycle: got %0d, required 3", first_wait);
        end
    endtask

    task automatic test_len55();
        wq_t got;
        run_msg(fill_bytes(55, 8'h61), 0, 1'b0, "len55", got);
        if (got.size() >= 16) begin
            total++; if (got[13] !== 32'h80616161) begin bad++; $display("FAIL len55 word13: got %08h, required 80616161", got[13]); end
            total++; if (got[14] !== 32'h000001b8) begin bad++; $display("FAIL len55 word14: got %08h, required 000001b8", got[14]); end
        end
    endtask

    task automatic test_len56();
        wq_t got;
        run_msg(fill_bytes(56, 8'h61), 0, 1'b1, "len56", got);
        if (got.size() >= 32) begin
            total++; if (got[14] !== 32'h00000080) begin bad++; $display("FAIL len56 b1_word14: got %08h, required 00000080", got[14]); end
            total++; if (got[16] !== 32'h0)        begin bad++; $display("FAIL len56 b2_word0: got %08h, required 0", got[16]); end
            total++; if (got[30] !== 32'h000001c0) begin bad++; $display("FAIL len56 b2_word14: got %08h, required 000001c0", got[30]); end
        end
    endtask

    task automatic test_len64();
        wq_t got;
        run_msg(rand_bytes(64), 0, 1'b1, "len64", got);
        if (got.size() >= 32) begin
            total++; if (got[16] !== 32'h00000080) begin bad++; $display("FAIL len64 b2_word0: got %08h, required 00000080", got[16]); end
            total++; if (got[30] !== 32'h00000200) begin bad++; $display("FAIL len64 b2_word14: got %08h, required 00000200", got[30]); end
        end
    endtask

    task automatic test_random_200();
        wq_t got;
        run_msg(rand_bytes(200), 30, 1'b1, "rand200", got);
    endtask

    task automatic test_abort();
        wq_t got;
        int dv0;
        rnd_rdy = 1'b1;
        send_bytes(rand_bytes(40), 0, 1'b0);
        repeat (3) @(negedge clk);
        dv0 = dv_cnt;
        #2 rst_n = 1'b0;
        #1;
        total++; if (core_rst_n !== 1'b0)    begin bad++; $display("FAIL abort core_rst_n: got %0b, required 0", core_rst_n); end
        total++; if (busy !== 1'b0)          begin bad++; $display("FAIL abort busy: got %0b, required 0", busy); end
        total++; if (core_write_en !== 1'b0) begin bad++; $display("FAIL abort core_write_en: got %0b, required 0", core_write_en); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (dv_cnt != dv0) begin
            bad++; $display("FAIL abort spurious_digest_valid: got %0d pulses, required 0", dv_cnt - dv0);
        end
        run_msg(abc_msg(), 10, 1'b1, "abort_abc", got);
        check_abc(got, "abort_abc");
    endtask

    task automatic test_back_to_back();
        wq_t got;
        run_msg(rand_bytes($urandom_range(1, 130)), 10, 1'b1, "b2b_first", got);
        run_msg(rand_bytes($urandom_range(1, 130)), 10, 1'b1, "b2b_second", got);
    endtask

    initial begin
        test_reset();
        test_abc();
        test_len55();
        test_len56();
        test_len64();
        test_random_200();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
